// File: rtl/itch_pkg.sv
// ==== itch_pkg : shared ITCH 5.0 type codes, type chars, frame lengths, encoder state | rev 1.0 ====
`default_nettype none

package itch_pkg;

  localparam logic [3:0] TYPE_ADD     = 4'd1;
  localparam logic [3:0] TYPE_CANCEL  = 4'd2;
  localparam logic [3:0] TYPE_DELETE  = 4'd3;
  localparam logic [3:0] TYPE_REPLACE = 4'd4;
  localparam logic [3:0] TYPE_EXEC    = 4'd5;
  localparam logic [3:0] TYPE_TRADE   = 4'd6;

  localparam logic [7:0] CHAR_ADD     = 8'h41;
  localparam logic [7:0] CHAR_CANCEL  = 8'h58;
  localparam logic [7:0] CHAR_DELETE  = 8'h44;
  localparam logic [7:0] CHAR_REPLACE = 8'h55;
  localparam logic [7:0] CHAR_EXEC    = 8'h45;
  localparam logic [7:0] CHAR_TRADE   = 8'h50;

  localparam logic [7:0] LEN_ADD      = 8'd36;
  localparam logic [7:0] LEN_CANCEL   = 8'd23;
  localparam logic [7:0] LEN_DELETE   = 8'd19;
  localparam logic [7:0] LEN_REPLACE  = 8'd35;
  localparam logic [7:0] LEN_EXEC     = 8'd31;
  localparam logic [7:0] LEN_TRADE    = 8'd44;

  // Widest frame (Trade) in bits; frames are packed left-aligned into this width.
  localparam int FULL_W = 352;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } enc_state_e;

endpackage

`default_nettype wire

// File: rtl/itch_frame_builder.sv
// ==== itch_frame_builder : cmd fields -> left-aligned big-endian ITCH frame + length | rev 1.0 ====
`default_nettype none

module itch_frame_builder
  import itch_pkg::*;
#(
  parameter int MAX_LEN = 44
) (
  input  logic [3:0]           type_i,
  input  logic [15:0]          stock_locate_i,
  input  logic [15:0]          tracking_i,
  input  logic [47:0]          timestamp_i,
  input  logic [63:0]          order_ref_i,
  input  logic [63:0]          new_order_ref_i,
  input  logic [7:0]           side_i,
  input  logic [31:0]          shares_i,
  input  logic [31:0]          price_i,
  input  logic [63:0]          stock_symbol_i,
  input  logic [63:0]          match_id_i,
  output logic [MAX_LEN*8-1:0] frame_o,
  output logic [7:0]           len_o,
  output logic                 legal_o
);

  localparam int PAD_W = MAX_LEN*8 - FULL_W;

  logic [79:0]       w_common;
  logic [FULL_W-1:0] w_full;

  assign w_common = {stock_locate_i, tracking_i, timestamp_i};

  always_comb begin
    w_full  = '0;
    len_o   = '0;
    legal_o = 1'b1;
    case (type_i)
      TYPE_ADD: begin
        len_o  = LEN_ADD;
        w_full = {CHAR_ADD, w_common, order_ref_i, side_i, shares_i,
                  stock_symbol_i, price_i, 64'd0};
      end
      TYPE_CANCEL: begin
        len_o  = LEN_CANCEL;
        w_full = {CHAR_CANCEL, w_common, order_ref_i, shares_i, 168'd0};
      end
      TYPE_DELETE: begin
        len_o  = LEN_DELETE;
        w_full = {CHAR_DELETE, w_common, order_ref_i, 200'd0};
      end
      TYPE_REPLACE: begin
        len_o  = LEN_REPLACE;
        w_full = {CHAR_REPLACE, w_common, order_ref_i, new_order_ref_i,
                  shares_i, price_i, 72'd0};
      end
      TYPE_EXEC: begin
        len_o  = LEN_EXEC;
        w_full = {CHAR_EXEC, w_common, order_ref_i, shares_i, match_id_i, 104'd0};
      end
      TYPE_TRADE: begin
        len_o  = LEN_TRADE;
        w_full = {CHAR_TRADE, w_common, order_ref_i, side_i, shares_i,
                  stock_symbol_i, price_i, match_id_i};
      end
      default: legal_o = 1'b0;
    endcase
  end

  // MAX_LEN must be at least 44; any extra width is zero padding on the right.
  generate
    if (PAD_W == 0) begin : g_exact
      assign frame_o = w_full;
    end else begin : g_pad
      assign frame_o = {w_full, {PAD_W{1'b0}}};
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/itch_message_encoder.sv
// ==== itch_message_encoder : command -> ITCH 5.0 byte stream, 1 byte/cycle with backpressure | rev 1.0 ====
`default_nettype none

module itch_message_encoder
  import itch_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int MAX_LEN    = 44
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_type,
  input  logic [15:0] cmd_stock_locate,
  input  logic [15:0] cmd_tracking,
  input  logic [47:0] cmd_timestamp,
  input  logic [63:0] cmd_order_ref,
  input  logic [63:0] cmd_new_order_ref,
  input  logic [7:0]  cmd_side,
  input  logic [31:0] cmd_shares,
  input  logic [31:0] cmd_price,
  input  logic [63:0] cmd_stock_symbol,
  input  logic [63:0] cmd_match_id,
  input  logic        out_ready,
  output logic [7:0]  byte_out,
  output logic        valid_out,
  output logic        sop_out,
  output logic        eop_out,
  output logic        cmd_err,
  output logic        busy
);

  localparam int         FW    = MAX_LEN * 8;
  localparam logic [3:0] GAP_N = 4'(GAP_CYCLES);

  enc_state_e    state_q, state_d;
  logic [FW-1:0] frame_q;
  logic [7:0]    byte_cnt_q;
  logic [7:0]    len_q;
  logic [3:0]    gap_cnt_q;
  logic          cmd_err_q;

  logic [FW-1:0] w_frame;
  logic [7:0]    w_len;
  logic          w_legal;
  logic          w_accept;
  logic          w_beat;
  logic          w_last;

  itch_frame_builder #(.MAX_LEN(MAX_LEN)) u_builder (
    .type_i          (cmd_type),
    .stock_locate_i  (cmd_stock_locate),
    .tracking_i      (cmd_tracking),
    .timestamp_i     (cmd_timestamp),
    .order_ref_i     (cmd_order_ref),
    .new_order_ref_i (cmd_new_order_ref),
    .side_i          (cmd_side),
    .shares_i        (cmd_shares),
    .price_i         (cmd_price),
    .stock_symbol_i  (cmd_stock_symbol),
    .match_id_i      (cmd_match_id),
    .frame_o         (w_frame),
    .len_o           (w_len),
    .legal_o         (w_legal)
  );

  assign cmd_ready = (state_q == ST_IDLE) && rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_beat    = (state_q == ST_SEND) && out_ready;
  assign w_last    = (byte_cnt_q == (len_q - 8'd1));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept && w_legal) state_d = ST_SEND;
      ST_SEND: if (w_beat && w_last) state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (gap_cnt_q <= 4'd1) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte lane is always the MSB of the left-aligned frame; shifting exposes the next byte.
  always_comb begin
    byte_out  = '0;
    valid_out = 1'b0;
    sop_out   = 1'b0;
    eop_out   = 1'b0;
    if (state_q == ST_SEND) begin
      byte_out  = frame_q[FW-1 -: 8];
      valid_out = 1'b1;
      sop_out   = (byte_cnt_q == 8'd0);
      eop_out   = w_last;
    end
    busy    = (state_q != ST_IDLE);
    cmd_err = cmd_err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_q    <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      gap_cnt_q  <= '0;
      cmd_err_q  <= 1'b0;
    end else begin
      cmd_err_q <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        frame_q    <= w_frame;
        byte_cnt_q <= 8'd0;
        len_q      <= w_len;
      end else if (w_beat) begin
        frame_q    <= frame_q << 8;
        byte_cnt_q <= byte_cnt_q + 8'd1;
      end
      if (state_q == ST_SEND) gap_cnt_q <= GAP_N;
      else if (state_q == ST_GAP) gap_cnt_q <= gap_cnt_q - 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_itch_message_encoder.sv
// ==== tb_itch_message_encoder : directed vector bench for itch_message_encoder | rev 1.0 ====
`default_nettype none

module tb_itch_message_encoder;

  typedef struct {
    logic [3:0]   typ;
    logic [15:0]  loc;
    logic [15:0]  trk;
    logic [47:0]  ts;
    logic [63:0]  oref;
    logic [63:0]  nref;
    logic [7:0]   side;
    logic [31:0]  shares;
    logic [31:0]  price;
    logic [63:0]  stock;
    logic [63:0]  match;
    int           len;
    logic [351:0] exp;   // expected frame, right-aligned: byte i at [(len-1-i)*8 +: 8]
  } vec_t;

  localparam logic [63:0] G64 = 64'hBADC0FFEE0DDF00D;
  localparam logic [31:0] G32 = 32'hCAFEF00D;
  localparam logic [7:0]  G8  = 8'h5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_type;
  logic [15:0] cmd_stock_locate;
  logic [15:0] cmd_tracking;
  logic [47:0] cmd_timestamp;
  logic [63:0] cmd_order_ref;
  logic [63:0] cmd_new_order_ref;
  logic [7:0]  cmd_side;
  logic [31:0] cmd_shares;
  logic [31:0] cmd_price;
  logic [63:0] cmd_stock_symbol;
  logic [63:0] cmd_match_id;
  logic        out_ready;
  logic [7:0]  byte_out;
  logic        valid_out;
  logic        sop_out;
  logic        eop_out;
  logic        cmd_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  vec_t vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  itch_message_encoder #(.GAP_CYCLES(1), .MAX_LEN(44)) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_type          (cmd_type),
    .cmd_stock_locate  (cmd_stock_locate),
    .cmd_tracking      (cmd_tracking),
    .cmd_timestamp     (cmd_timestamp),
    .cmd_order_ref     (cmd_order_ref),
    .cmd_new_order_ref (cmd_new_order_ref),
    .cmd_side          (cmd_side),
    .cmd_shares        (cmd_shares),
    .cmd_price         (cmd_price),
    .cmd_stock_symbol  (cmd_stock_symbol),
    .cmd_match_id      (cmd_match_id),
    .out_ready         (out_ready),
    .byte_out          (byte_out),
    .valid_out         (valid_out),
    .sop_out           (sop_out),
    .eop_out           (eop_out),
    .cmd_err           (cmd_err),
    .busy              (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    cmd_type          = v.typ;
    cmd_stock_locate  = v.loc;
    cmd_tracking      = v.trk;
    cmd_timestamp     = v.ts;
    cmd_order_ref     = v.oref;
    cmd_new_order_ref = v.nref;
    cmd_side          = v.side;
    cmd_shares        = v.shares;
    cmd_price         = v.price;
    cmd_stock_symbol  = v.stock;
    cmd_match_id      = v.match;
  endtask

  // Fields change right after accept so a frame built from late inputs shows up.
  task automatic scramble();
    cmd_type          = 4'hF;
    cmd_stock_locate  = ~cmd_stock_locate;
    cmd_tracking      = ~cmd_tracking;
    cmd_timestamp     = ~cmd_timestamp;
    cmd_order_ref     = ~cmd_order_ref;
    cmd_new_order_ref = ~cmd_new_order_ref;
    cmd_side          = ~cmd_side;
    cmd_shares        = ~cmd_shares;
    cmd_price         = ~cmd_price;
    cmd_stock_symbol  = ~cmd_stock_symbol;
    cmd_match_id      = ~cmd_match_id;
  endtask

  function automatic logic [7:0] exp_byte(input vec_t v, input int i);
    return v.exp[(v.len-1-i)*8 +: 8];
  endfunction

  // Called at a negedge with cmd_valid high; returns at the negedge after the accept edge.
  task automatic accept_cmd(output int acc);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    scramble();
  endtask

  task automatic issue(input vec_t v, output int acc);
    @(negedge clk);
    drive(v);
    cmd_valid = 1'b1;
    accept_cmd(acc);
  endtask

  // Returns at the negedge following acceptance of the eop byte.
  task automatic collect(input vec_t v, input bit stall);
    int i = 0;
    int k = 0;
    bit prev_st = 1'b0;
    logic [7:0] prev_b = 8'h00;
    bit rdy;
    while (i < v.len && k < 400) begin
      rdy = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      out_ready = rdy;
      if (prev_st) chk("stall_hold", {56'd0, byte_out}, {56'd0, prev_b});
      if (!valid_out) begin
        chk("valid_in_frame", 64'(valid_out), 64'd1);
        break;
      end
      if (rdy) begin
        chk("frame_byte", {54'd0, sop_out, eop_out, byte_out},
            {54'd0, (i == 0), (i == v.len-1), exp_byte(v, i)});
        i++;
        prev_st = 1'b0;
      end else begin
        prev_st = 1'b1;
        prev_b  = byte_out;
      end
      k++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("frame_len", 64'(i), 64'(v.len));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;

    vecs[0] = '{4'd3, 16'h0001, 16'h0002, 48'h112233445566, 64'h0102030405060708, G64, G8,
                G32, G32, G64, G64, 19,
                352'h44_0001_0002_112233445566_0102030405060708};
    vecs[1] = '{4'd1, 16'h0A0B, 16'h0C0D, 48'h000012345678, 64'hA1A2A3A4A5A6A7A8, G64, 8'h42,
                32'd100, 32'h0001E240, 64'h4141504C20202020, G64, 36,
                352'h41_0A0B_0C0D_000012345678_A1A2A3A4A5A6A7A8_42_00000064_4141504C20202020_0001E240};
    vecs[2] = '{4'd2, 16'h1111, 16'h2222, 48'h0A0B0C0D0E0F, 64'h1000000000000001, G64, G8,
                32'd300, G32, G64, G64, 23,
                352'h58_1111_2222_0A0B0C0D0E0F_1000000000000001_0000012C};
    vecs[3] = '{4'd4, 16'h0102, 16'h0304, 48'h010203040506, 64'hC0C1C2C3C4C5C6C7,
                64'hD0D1D2D3D4D5D6D7, G8, 32'd1000, 32'h00989680, G64, G64, 35,
                352'h55_0102_0304_010203040506_C0C1C2C3C4C5C6C7_D0D1D2D3D4D5D6D7_000003E8_00989680};
    vecs[4] = '{4'd5, 16'h7777, 16'h8888, 48'hFFEEDDCCBBAA, 64'h0123456789ABCDEF, G64, G8,
                32'd50, G32, G64, 64'h00000000DEADBEEF, 31,
                352'h45_7777_8888_FFEEDDCCBBAA_0123456789ABCDEF_00000032_00000000DEADBEEF};
    vecs[5] = '{4'd6, 16'h0042, 16'h0043, 48'h000102030405, 64'h2000000000000002, G64, 8'h53,
                32'd500, 32'h00123456, 64'h4D53465420202020, 64'h0000000000ABCDEF, 44,
                352'h50_0042_0043_000102030405_2000000000000002_53_000001F4_4D53465420202020_00123456_0000000000ABCDEF};

    rst       = 1'b0;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    drive(vecs[0]);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {50'd0, byte_out, valid_out, sop_out, eop_out, cmd_err, busy, cmd_ready},
        64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {62'd0, cmd_ready, busy}, 64'd2);

    // Table: delete, add (stalled), cancel, replace (stalled), exec, trade.
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i], a0);
      chk("first_byte", {54'd0, valid_out, sop_out, byte_out}, {54'd0, 2'b11, exp_byte(vecs[i], 0)});
      collect(vecs[i], (i == 1) || (i == 3));
      chk("post_frame", {61'd0, valid_out, cmd_ready, busy}, 64'd1);
    end

    // Back-to-back trades: period = len + GAP + 1 = 46 cycles.
    issue(vecs[5], a0);
    collect(vecs[5], 1'b0);
    chk("b2b_gap", {61'd0, valid_out, cmd_ready, busy}, 64'd1);
    issue(vecs[5], a1);
    chk("b2b_period", 64'(a1 - a0), 64'd46);
    chk("b2b_first", {54'd0, valid_out, sop_out, byte_out}, {54'd0, 2'b11, 8'h50});
    collect(vecs[5], 1'b0);
    chk("b2b_post", {61'd0, valid_out, cmd_ready, busy}, 64'd1);

    // Illegal type, then a cancel accepted on the very next cycle.
    @(negedge clk);
    @(negedge clk);
    drive(vecs[2]);
    cmd_type  = 4'd9;
    cmd_valid = 1'b1;
    accept_cmd(a0);
    chk("err_pulse", {60'd0, cmd_err, valid_out, cmd_ready, busy}, 64'b1010);
    drive(vecs[2]);
    cmd_valid = 1'b1;
    accept_cmd(a1);
    chk("err_next_accept", 64'(a1 - a0), 64'd1);
    chk("err_clear", {54'd0, cmd_err, valid_out, byte_out}, {54'd0, 2'b01, 8'h58});
    collect(vecs[2], 1'b0);
    chk("err_post", {61'd0, valid_out, cmd_ready, busy}, 64'd1);

    // Reset while byte 10 of a replace is on the bus.
    issue(vecs[3], a0);
    repeat (10) @(negedge clk);
    chk("replace_byte10", {56'd0, byte_out}, {56'd0, exp_byte(vecs[3], 10)});
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {50'd0, byte_out, valid_out, sop_out, eop_out, cmd_err, busy, cmd_ready},
        64'd0);
    @(negedge clk);
    chk("abort_hold", {62'd0, valid_out, busy}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", {62'd0, cmd_ready, valid_out}, 64'd2);
    issue(vecs[4], a0);
    chk("exec_first", {54'd0, valid_out, sop_out, byte_out}, {54'd0, 2'b11, 8'h45});
    collect(vecs[4], 1'b0);
    chk("exec_post", {61'd0, valid_out, cmd_ready, busy}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
